fp_align_pipe: RTL and testbench

//  Parametrised, pipelined exponent-compare / mantissa-align stage for the FP adder datapath.
//  - Accepts two packed IEEE-754 operands over a valid/ready handshake.
//  - Emits the common exponent, both mantissas aligned to it, G/R/S bits and a special-case class.
//  - Sits between operand capture and the add/subtract stage; successor to the combinational aligner.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_shift_sticky.sv | 16 +
 rtl/fp_align_pipe.sv | 123 ++++++++++++
 tb/tb_fp_align_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared types for the FP add alignment datapath.
//   fp_class_t  - special-case class carried alongside aligned operands
//   fp_op_t     - unpacked operand record sized for the widest supported format
//   fp_classify - folds per-operand NaN/Inf flags into the pair class
package fp_pkg;
  localparam int MAX_EXP_W = 11;
  localparam int MAX_MAN_W = 52;
  typedef enum logic [1:0] {NORM = 2'd0, NAN = 2'd1, INF = 2'd2} fp_class_t;
  typedef struct packed {
    logic                 sign;
    logic [MAX_EXP_W-1:0] exp;
    logic [MAX_MAN_W-1:0] frac;
    logic                 hidden;
  } fp_op_t;
  function automatic fp_class_t fp_classify(input logic nan_a, nan_b, inf_a, inf_b, sign_a, sign_b);
    if (nan_a | nan_b | (inf_a & inf_b & (sign_a ^ sign_b))) return NAN;
    if (inf_a | inf_b) return INF;
    return NORM;
  endfunction
endpackage

// File: rtl/fp_shift_sticky.sv
// fp_shift_sticky: logical right shift that also reports the OR of every bit shifted out.
//   val/amt in, res = val >> amt, sticky = |(bits of val below amt)
module fp_shift_sticky #(
  parameter int WIDTH = 26,
  parameter int SH_W  = 8
) (
  input  logic [WIDTH-1:0] val,
  input  logic [SH_W-1:0]  amt,
  output logic [WIDTH-1:0] res,
  output logic             sticky
);
  logic [WIDTH-1:0] ones;
  assign ones   = '1;
  assign res    = val >> amt;
  assign sticky = |(val & ~(ones << amt));
endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage exponent compare / mantissa align for the FP adder.
//   in_valid/in_ready/in_a/in_b      operand pair handshake {sign, exp, frac}
//   out_valid/out_ready              result handshake
//   out_sign_a/b, out_exp            signs and common exponent
//   out_man_a/b, out_grs, out_class  aligned mantissas, guard/round/sticky, special class
module fp_align_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign_a,
  output logic               out_sign_b,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MAN_W:0]     out_man_a,
  output logic [MAN_W:0]     out_man_b,
  output logic [2:0]         out_grs,
  output logic [1:0]         out_class
);
  localparam int FW = EXP_W + MAN_W + 1;
  localparam int XW = MAN_W + 3;
  function automatic fp_op_t unpack(input logic [FW-1:0] x);
    fp_op_t u;
    u.sign   = x[FW-1];
    u.exp    = MAX_EXP_W'(x[FW-2 -: EXP_W]);
    u.frac   = MAX_MAN_W'(x[MAN_W-1:0]);
    u.hidden = |x[FW-2 -: EXP_W];
    return u;
  endfunction
  fp_op_t ua, ub;
  logic [EXP_W-1:0] ea, eb, xa, xb, big_e, diff;
  logic [MAN_W-1:0] fa, fb;
  logic swap, nan_a, nan_b, inf_a, inf_b;
  always_comb begin
    ua    = unpack(in_a);
    ub    = unpack(in_b);
    ea    = EXP_W'(ua.exp);
    eb    = EXP_W'(ub.exp);
    fa    = MAN_W'(ua.frac);
    fb    = MAN_W'(ub.frac);
    // subnormals share the scale of exponent 1
    xa    = ea == '0 ? EXP_W'(1) : ea;
    xb    = eb == '0 ? EXP_W'(1) : eb;
    swap  = xb > xa;
    big_e = (ea == '0 && eb == '0) ? '0 : swap ? xb : xa;
    diff  = swap ? xb - xa : xa - xb;
    nan_a = &ea & |fa;
    nan_b = &eb & |fb;
    inf_a = &ea & ~|fa;
    inf_b = &eb & ~|fb;
  end
  logic s1_v, s1_sa, s1_sb, s1_swap, s2_ld;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [MAN_W:0] s1_big, s1_small;
  fp_class_t s1_cls;
  assign s2_ld    = !out_valid | out_ready;
  assign in_ready = !s1_v | s2_ld;
  logic [XW-1:0] sh_res;
  logic sh_st, special;
  logic [MAN_W:0] small_al;
  logic [2:0] grs;
  fp_shift_sticky #(.WIDTH(XW), .SH_W(EXP_W)) u_shift (
    .val   ({s1_small, 2'b00}),
    .amt   (s1_diff),
    .res   (sh_res),
    .sticky(sh_st)
  );
  // specials keep both mantissas as captured
  assign special  = s1_cls != NORM;
  assign small_al = special ? s1_small : sh_res[XW-1:2];
  assign grs      = special ? 3'b000 : {sh_res[1:0], sh_st};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1_sa      <= 1'b0;
      s1_sb      <= 1'b0;
      s1_swap    <= 1'b0;
      s1_exp     <= '0;
      s1_diff    <= '0;
      s1_big     <= '0;
      s1_small   <= '0;
      s1_cls     <= NORM;
      out_valid  <= 1'b0;
      out_sign_a <= 1'b0;
      out_sign_b <= 1'b0;
      out_exp    <= '0;
      out_man_a  <= '0;
      out_man_b  <= '0;
      out_grs    <= '0;
      out_class  <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (in_valid && in_ready) begin
        s1_sa    <= ua.sign;
        s1_sb    <= ub.sign;
        s1_swap  <= swap;
        s1_exp   <= big_e;
        s1_diff  <= diff;
        s1_big   <= swap ? {ub.hidden, fb} : {ua.hidden, fa};
        s1_small <= swap ? {ua.hidden, fa} : {ub.hidden, fb};
        s1_cls   <= fp_classify(nan_a, nan_b, inf_a, inf_b, ua.sign, ub.sign);
      end
      if (s2_ld) out_valid <= s1_v;
      if (s2_ld && s1_v) begin
        out_sign_a <= s1_sa;
        out_sign_b <= s1_sb;
        out_exp    <= s1_exp;
        out_man_a  <= s1_swap ? small_al : s1_big;
        out_man_b  <= s1_swap ? s1_big : small_al;
        out_grs    <= grs;
        out_class  <= s1_cls;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: randomized scoreboard bench for fp_align_pipe (binary32).
module tb_fp_align_pipe;
  import fp_pkg::*;
  typedef struct packed {
    logic        sa;
    logic        sb;
    logic [7:0]  e;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [2:0]  grs;
    logic [1:0]  cls;
  } res_t;
  logic clk = 1'b0, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic out_sign_a, out_sign_b;
  logic [7:0] out_exp;
  logic [23:0] out_man_a, out_man_b;
  logic [2:0] out_grs;
  logic [1:0] out_class;
  int n_chk = 0, n_pass = 0, acc_cnt = 0;
  logic rand_mode = 1'b0, force_ready = 1'b1, held = 1'b0, stall_done;
  res_t q[$];
  res_t got, held_val;
  fp_align_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_a(out_sign_a), .out_sign_b(out_sign_b), .out_exp(out_exp),
    .out_man_a(out_man_a), .out_man_b(out_man_b), .out_grs(out_grs), .out_class(out_class)
  );
  always #5 clk = ~clk;
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint ea, eb, fa, fb, ha, hb, xa, xb, mfa, mfb, d, sm, sh, lost;
    bit na, nb, ia, ib;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    ha = (ea != 0) ? 1 : 0; hb = (eb != 0) ? 1 : 0;
    xa = ha != 0 ? ea : 1; xb = hb != 0 ? eb : 1;
    mfa = ha * 8388608 + fa; mfb = hb * 8388608 + fb;
    na = ea == 255 && fa != 0; nb = eb == 255 && fb != 0;
    ia = ea == 255 && fa == 0; ib = eb == 255 && fb == 0;
    r.sa = a[31]; r.sb = b[31];
    r.e = (ea == 0 && eb == 0) ? 8'd0 : 8'(xa > xb ? xa : xb);
    r.cls = (na || nb || (ia && ib && a[31] != b[31])) ? NAN : (ia || ib) ? INF : NORM;
    r.ma = 24'(mfa); r.mb = 24'(mfb); r.grs = 3'b000;
    if (r.cls == NORM) begin
      d = xa > xb ? xa - xb : xb - xa;
      sm = 4 * (xa >= xb ? mfb : mfa);
      sh = d >= 26 ? 0 : sm / (longint'(1) << d);
      lost = d >= 26 ? sm : sm % (longint'(1) << d);
      if (xa >= xb) r.mb = 24'(sh / 4); else r.ma = 24'(sh / 4);
      r.grs = 3'((sh % 4) * 2 + (lost != 0 ? 1 : 0));
    end
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] g, input logic [63:0] e);
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, g, e);
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    n_chk++;
    $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
  endtask
  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask
  function automatic logic [31:0] rnd_op(input logic [7:0] near);
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    int k;
    s = 1'($urandom);
    f = 23'($urandom);
    k = $urandom_range(0, 11);
    e = near + 8'($urandom_range(0, 60)) - 8'd30;
    case (k)
      0: return $urandom;
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, f | 23'd1};
      3: return {s, 8'h00, f};
      4: return {s, 8'h00, 23'd0};
      default: return {s, e, f};
    endcase
  endfunction
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      got = {out_sign_a, out_sign_b, out_exp, out_man_a, out_man_b, out_grs, out_class};
      if (held) check("hold_stable", {out_valid, got}, {1'b1, held_val});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL out_unexpected: got %h with no pending input", got);
        end else check("out_data", got, q.pop_front());
      end
      held = out_valid && !out_ready;
      held_val = got;
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b));
        acc_cnt++;
      end
    end else held = 1'b0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc0;
    logic [7:0] base;
    logic [31:0] a, b;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", {out_sign_a, out_sign_b, out_exp, out_man_a, out_man_b, out_grs, out_class}, 0);
    @(negedge clk) rst_n = 1'b1;
    check("pin_1p1", model(32'h3F800000, 32'h3F800000), {2'b00, 8'h7F, 24'h800000, 24'h800000, 3'b000, NORM});
    check("pin_shift1", model(32'h40000000, 32'h3F800001), {2'b00, 8'h80, 24'h800000, 24'h400000, 3'b100, NORM});
    check("pin_diff30", model(32'h3F800000, 32'h30800000), {2'b00, 8'h7F, 24'h800000, 24'h000000, 3'b001, NORM});
    check("pin_infnan", model(32'h7F800000, 32'hFF800000), {2'b01, 8'hFF, 24'h800000, 24'h800000, 3'b000, NAN});
    check("pin_inf", model(32'h7F800000, 32'h3F800000), {2'b00, 8'hFF, 24'h800000, 24'h800000, 3'b000, INF});
    check("pin_subn", model(32'h00000001, 32'h3F800000), {2'b00, 8'h7F, 24'h000000, 24'h800000, 3'b001, NORM});
    send(32'h3F800000, 32'h3F800000);
    idle();
    @(negedge clk);
    check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", out_valid, 1);
    check("lat_exp", out_exp, 8'h7F);
    send(32'h40000000, 32'h3F800001);
    send(32'h3F800000, 32'h30800000);
    send(32'h7F800000, 32'hFF800000);
    send(32'h7F800000, 32'h3F800000);
    send(32'h00000001, 32'h3F800000);
    send(32'h00000000, 32'h80000000);
    idle();
    drain();
    force_ready = 1'b0;
    @(posedge clk); #2;
    acc0 = acc_cnt;
    stall_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'h3F800000 + 32'(i), 32'h3E000000 + 32'(i << 20));
        idle();
        stall_done = 1'b1;
      end
    join_none
    repeat (5) @(negedge clk);
    check("stall_accepted", 64'(acc_cnt - acc0), 64'd2);
    check("stall_in_ready", in_ready, 0);
    force_ready = 1'b1;
    for (int i = 0; i < 200 && !stall_done; i++) @(negedge clk);
    check("stall_done", stall_done, 1);
    drain();
    force_ready = 1'b0;
    @(posedge clk);
    send(32'h40400000, 32'h3F800000);
    send(32'h41000000, 32'h3F000000);
    idle();
    repeat (2) @(negedge clk);
    check("inflight_valid", out_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    force_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      base = 8'($urandom_range(20, 235));
      a = rnd_op(base);
      b = rnd_op(base);
      send(a, b);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
